// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the multi-byte adder sequencer.
package adder_seq_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  function automatic int idx_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/adder_seq_opreg.sv
// Operand holding registers (A and pre-inverted B) with a byte-select mux driven by the byte index.
module adder_seq_opreg
  import adder_seq_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int W     = BYTE_W * BYTES,
  parameter int IDX_W = idx_width(BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  input  logic              in_sub,
  input  logic [IDX_W-1:0]  idx,
  output logic [BYTE_W-1:0] a_byte,
  output logic [BYTE_W-1:0] b_byte
);

  logic [BYTES-1:0][BYTE_W-1:0] a_q, a_d;
  logic [BYTES-1:0][BYTE_W-1:0] bx_q, bx_d;

  always_comb begin
    a_d  = a_q;
    bx_d = bx_q;
    if (load) begin
      a_d  = in_a;
      bx_d = in_b ^ {W{in_sub}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      bx_q <= '0;
    end else begin
      a_q  <= a_d;
      bx_q <= bx_d;
    end
  end

  assign a_byte = a_q[idx];
  assign b_byte = bx_q[idx];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequences one BYTES*8-bit add/sub through an external 8-bit ripple adder, LSB byte first,
// chaining the carry through a register; valid/ready on both request and result sides.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int W     = BYTE_W * BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  input  logic              in_sub,
  input  logic              in_ci,
  output logic [BYTE_W-1:0] add_a,
  output logic [BYTE_W-1:0] add_b,
  output logic              add_ci,
  input  logic [BYTE_W-1:0] add_sum,
  input  logic [BYTE_W-1:0] add_co,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_sum,
  output logic              out_co,
  output logic              out_ovf,
  output logic              out_zero
);

  localparam int IDX_W = idx_width(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         carry_q, carry_d;
  logic [BYTES-1:0][BYTE_W-1:0] sum_q, sum_d;
  logic                         co_q, co_d;
  logic                         ovf_q, ovf_d;
  logic                         load;
  logic [BYTE_W-1:0]            op_a, op_b;

  adder_seq_opreg #(.BYTES(BYTES)) u_opreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_sub (in_sub),
    .idx    (idx_q),
    .a_byte (op_a),
    .b_byte (op_b)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    add_a   = '0;
    add_b   = '0;
    add_ci  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          idx_d   = '0;
          // Seeding the chain register with the request carry-in makes byte 0 use it directly.
          carry_d = in_sub | in_ci;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        add_a        = op_a;
        add_b        = op_b;
        add_ci       = carry_q;
        sum_d[idx_q] = add_sum;
        carry_d      = add_co[BYTE_W-1];
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          co_d    = add_co[BYTE_W-1];
          ovf_d   = add_co[BYTE_W-1] ^ add_co[BYTE_W-2];
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = sum_q;
  assign out_co    = co_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = (sum_q == '0);

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench: adder_seq_ctrl driving an 8-bit full-adder chain model, BYTES=4.
module tb_adder_seq_ctrl;

  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_sub, in_ci;
  logic [W-1:0]  in_a, in_b;
  logic [7:0]    add_a, add_b, add_sum, add_co;
  logic          add_ci;
  logic          out_valid, out_ready, out_co, out_ovf, out_zero;
  logic [W-1:0]  out_sum;

  int checks = 0;
  int errors = 0;

  adder_seq_ctrl #(.BYTES(BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_ci(in_ci),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_sum(add_sum), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_co(out_co), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  // External 8-bit ripple chain of full adders with per-bit carry out.
  function automatic logic [15:0] fa_chain(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [7:0] s, co;
    logic c;
    c = ci;
    for (int i = 0; i < 8; i++) begin
      s[i]  = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      co[i] = c;
    end
    return {co, s};
  endfunction

  assign {add_co, add_sum} = fa_chain(add_a, add_b, add_ci);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub, ci;
    logic [W-1:0] sum;
    logic         co, ovf, zero;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an op at a negedge, accept at the next posedge, return cycles until out_valid.
  task automatic issue_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, input logic ci, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", W'(in_ready), W'(1));
    in_a = a; in_b = b; in_sub = sub; in_ci = ci; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("in_ready_after_release", W'(in_ready), W'(1));
    chk("out_valid_after_release", W'(out_valid), W'(0));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    issue_and_wait(v.a, v.b, v.sub, v.ci, lat);
    chk({tag, "_latency"}, W'(lat), W'(BYTES));
    @(negedge clk);
    chk({tag, "_sum"},  out_sum,     v.sum);
    chk({tag, "_co"},   W'(out_co),  W'(v.co));
    chk({tag, "_ovf"},  W'(out_ovf), W'(v.ovf));
    chk({tag, "_zero"}, W'(out_zero), W'(v.zero));
    release_result();
  endtask

  initial begin
    int lat;
    vecs[0] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_ci = 1'b0;
    #12;
    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_sum",   out_sum,       '0);
    chk("rst_out_co",    W'(out_co),    W'(0));
    chk("rst_out_ovf",   W'(out_ovf),   W'(0));
    chk("rst_out_zero",  W'(out_zero),  W'(1));
    chk("rst_add_bus",   W'({add_a, add_b, add_ci}), '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: result must hold and new request must wait for the handshake.
    issue_and_wait(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, lat);
    chk("bp_first_latency", W'(lat), W'(BYTES));
    @(negedge clk);
    in_a = 32'h0000_0100; in_b = 32'h0000_0200; in_sub = 1'b0; in_ci = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_in_ready",  W'(in_ready),  W'(0));
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_hold_sum",  out_sum,       32'h0000_0003);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_idle_in_ready",  W'(in_ready),  W'(1));
    chk("bp_idle_out_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_second_accepted", W'(in_ready), W'(0));
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    chk("bp_second_latency", W'(lat), W'(BYTES));
    chk("bp_second_sum", out_sum, 32'h0000_0300);
    release_result();

    // Reset during byte 2 of a run.
    @(negedge clk);
    in_a = 32'h4433_2211; in_b = 32'h0000_0000; in_sub = 1'b0; in_ci = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midrun_add_a_k2", W'(add_a), W'(8'h33));
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", W'(out_valid), W'(0));
    chk("midrun_rst_in_ready",  W'(in_ready),  W'(1));
    chk("midrun_rst_add_bus",   W'({add_a, add_b, add_ci}), '0);
    chk("midrun_rst_out_sum",   out_sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
